// File: rtl/riscv_pkg.sv
// Shared encodings for the load/store sequencer: access types, FSM states, latched op.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    // Only the low address bits are needed after issue; the word address lives in mem_addr.
    typedef struct packed {
        logic       is_store;
        logic [2:0] load_type;
        logic [1:0] store_type;
        logic [1:0] addr_lo;
    } lsu_op_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane logic: misalign detect, byte enables, store replication, load extension.
module lsu_lane_align
    import riscv_pkg::*;
(
    input  logic            is_store,
    input  logic [2:0]      load_type,
    input  logic [1:0]      store_type,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic            misalign_c,
    output logic [3:0]      be_c,
    output logic [XLEN-1:0] wdata_c,
    output logic [XLEN-1:0] rdata_ext_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Request side; reserved encodings fall through to the word case.
    always_comb begin
        misalign_c = 1'b0;
        be_c       = 4'b0000;
        wdata_c    = '0;
        if (is_store) begin
            case (store_type)
                ST_SB: begin
                    be_c    = 4'b0001 << addr_lo;
                    wdata_c = {4{wdata[7:0]}};
                end
                ST_SH: begin
                    misalign_c = addr_lo[0];
                    be_c       = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata_c    = {2{wdata[15:0]}};
                end
                default: begin
                    misalign_c = |addr_lo;
                    be_c       = 4'b1111;
                    wdata_c    = wdata;
                end
            endcase
        end else begin
            case (load_type)
                LD_LB, LD_LBU: be_c = 4'b0001 << addr_lo;
                LD_LH, LD_LHU: begin
                    misalign_c = addr_lo[0];
                    be_c       = addr_lo[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    misalign_c = |addr_lo;
                    be_c       = 4'b1111;
                end
            endcase
        end
    end

    // Response side: pick the addressed lane and extend.
    always_comb begin
        byte_sel    = rdata[7:0];
        half_sel    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        rdata_ext_c = rdata;
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        case (load_type)
            LD_LB:   rdata_ext_c = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  rdata_ext_c = {24'h000000, byte_sel};
            LD_LH:   rdata_ext_c = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  rdata_ext_c = {16'h0000, half_sel};
            default: rdata_ext_c = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// Multi-cycle load/store sequencer: one word-aligned bus transaction per access, with timeout.
module lsu_mem_sequencer
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_load,
    input  logic            req_store,
    input  logic [2:0]      load_type,
    input  logic [1:0]      store_type,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] rdata_ext,
    output logic            misalign,
    output logic            bus_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    lsu_op_t         op_q, op_d, op_in, op_sel;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic            done_q, done_d;
    logic            misalign_q, misalign_d;
    logic            bus_err_q, bus_err_d;
    logic [XLEN-1:0] rdata_ext_q, rdata_ext_d;

    logic            misalign_c;
    logic [3:0]      be_c;
    logic [XLEN-1:0] wdata_c;
    logic [XLEN-1:0] rdata_ext_c;

    // Live inputs drive the lane logic while idle; the latched op is used for the response.
    always_comb begin
        op_in.is_store   = req_store;
        op_in.load_type  = load_type;
        op_in.store_type = store_type;
        op_in.addr_lo    = addr[1:0];
        op_sel           = (state_q == IDLE) ? op_in : op_q;
    end

    lsu_lane_align u_lane_align (
        .is_store    (op_sel.is_store),
        .load_type   (op_sel.load_type),
        .store_type  (op_sel.store_type),
        .addr_lo     (op_sel.addr_lo),
        .wdata       (wdata),
        .rdata       (mem_rdata),
        .misalign_c  (misalign_c),
        .be_c        (be_c),
        .wdata_c     (wdata_c),
        .rdata_ext_c (rdata_ext_c)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        rdata_ext_d = rdata_ext_q;
        case (state_q)
            IDLE: begin
                if (req_store || req_load) begin
                    if (misalign_c) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        misalign_d  = 1'b1;
                        rdata_ext_d = '0;
                    end else begin
                        state_d     = REQ;
                        mem_req_d   = 1'b1;
                        op_d        = op_in;
                        mem_we_d    = req_store;
                        mem_addr_d  = {addr[XLEN-1:2], 2'b00};
                        mem_be_d    = be_c;
                        mem_wdata_d = wdata_c;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    rdata_ext_d = op_q.is_store ? '0 : rdata_ext_c;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    bus_err_d   = 1'b1;
                    rdata_ext_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            rdata_ext_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
            rdata_ext_q <= rdata_ext_d;
        end
    end

    // Simultaneous load and store is a decoder bug; store wins in hardware.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(req_load && req_store))
                else $error("lsu_mem_sequencer: req_load and req_store both asserted");
        end
    end

    assign stall     = ((state_q == IDLE) && (req_load || req_store)) ||
                       (state_q == REQ) || (state_q == RESP);
    assign done      = done_q;
    assign rdata_ext = rdata_ext_q;
    assign misalign  = misalign_q;
    assign bus_err   = bus_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Directed bench for lsu_mem_sequencer with hand-computed expectations.
module tb_lsu_mem_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_load, req_store;
    logic [2:0]  load_type;
    logic [1:0]  store_type;
    logic [31:0] addr, wdata;
    logic        stall, done, misalign, bus_err;
    logic [31:0] rdata_ext;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_mem_sequencer #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_load   (req_load),
        .req_store  (req_store),
        .load_type  (load_type),
        .store_type (store_type),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .done       (done),
        .rdata_ext  (rdata_ext),
        .misalign   (misalign),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Result of one access, captured by run_access.
    int          r_cyc, r_req_cnt;
    logic        r_seen, r_we, r_mis, r_berr, r_stall_done, r_stall_ok;
    logic [31:0] r_addr, r_wd, r_rd;
    logic [3:0]  r_be;

    // Starts an access at the next negedge; gnt on the gnt_cyc-th mem_req cycle,
    // rvalid rv_dly cycles after gnt (0 = never). Cycle 1 is the IDLE cycle.
    task automatic run_access(input logic st, input logic [2:0] lt, input logic [1:0] stt,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int gnt_cyc, input int rv_dly, input logic [31:0] rd);
        int   rv_wait;
        logic got_req;
        rv_wait = -1;
        got_req = 1'b0;
        r_cyc = 0; r_req_cnt = 0; r_seen = 1'b0; r_stall_ok = 1'b1;
        r_we = 1'b0; r_addr = '0; r_wd = '0; r_be = '0;
        @(negedge clk);
        req_load = !st; req_store = st; load_type = lt; store_type = stt;
        addr = a; wdata = wd;
        for (int i = 1; i <= 60 && !r_seen; i++) begin
            #1;
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
            if (done) begin
                r_seen = 1'b1; r_cyc = i;
                r_rd = rdata_ext; r_mis = misalign; r_berr = bus_err; r_stall_done = stall;
                req_load = 1'b0; req_store = 1'b0;
            end else begin
                r_stall_ok = r_stall_ok & stall;
                if (mem_req) begin
                    if (!got_req) begin
                        got_req = 1'b1;
                        r_we = mem_we; r_addr = mem_addr; r_be = mem_be; r_wd = mem_wdata;
                    end
                    r_req_cnt++;
                    if (r_req_cnt == gnt_cyc) begin
                        mem_gnt = 1'b1;
                        rv_wait = (rv_dly > 0) ? rv_dly : -1;
                    end
                end else if (rv_wait > 0) begin
                    rv_wait--;
                    if (rv_wait == 0) begin
                        mem_rvalid = 1'b1; mem_rdata = rd; rv_wait = -1;
                    end
                end
                @(negedge clk);
            end
        end
        check("done_seen", 32'(r_seen), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        req_load = 1'b0; req_store = 1'b0; load_type = 3'b000; store_type = 2'b00;
        addr = '0; wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #2;
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_rdata", rdata_ext, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // lw 0x100, same-cycle gnt, rvalid next cycle
        run_access(1'b0, 3'b010, 2'b00, 32'h100, 32'h0, 1, 1, 32'hDEADBEEF);
        check("lw_cyc", 32'(r_cyc), 32'd4);
        check("lw_be", 32'(r_be), 32'hF);
        check("lw_addr", r_addr, 32'h100);
        check("lw_we", 32'(r_we), 32'd0);
        check("lw_rdata", r_rd, 32'hDEADBEEF);
        check("lw_stall_busy", 32'(r_stall_ok), 32'd1);
        check("lw_stall_done", 32'(r_stall_done), 32'd0);
        check("lw_flags", {30'd0, r_mis, r_berr}, 32'd0);
        @(negedge clk); #1;
        check("lw_done_pulse", 32'(done), 32'd0);
        check("lw_rdata_hold", rdata_ext, 32'hDEADBEEF);

        // lb / lbu 0x103
        run_access(1'b0, 3'b000, 2'b00, 32'h103, 32'h0, 1, 1, 32'h80FF7F01);
        check("lb_be", 32'(r_be), 32'h8);
        check("lb_rdata", r_rd, 32'hFFFFFF80);
        run_access(1'b0, 3'b011, 2'b00, 32'h103, 32'h0, 1, 1, 32'h80FF7F01);
        check("lbu_rdata", r_rd, 32'h00000080);

        // lh 0x102 / lhu 0x100
        run_access(1'b0, 3'b001, 2'b00, 32'h102, 32'h0, 1, 1, 32'h80FF7F01);
        check("lh_be", 32'(r_be), 32'hC);
        check("lh_rdata", r_rd, 32'hFFFF80FF);
        run_access(1'b0, 3'b100, 2'b00, 32'h100, 32'h0, 1, 1, 32'h80FF7F81);
        check("lhu_be", 32'(r_be), 32'h3);
        check("lhu_rdata", r_rd, 32'h00007F81);

        // sh 0x202
        run_access(1'b1, 3'b000, 2'b01, 32'h202, 32'h1234ABCD, 1, 1, 32'h0);
        check("sh_we", 32'(r_we), 32'd1);
        check("sh_be", 32'(r_be), 32'hC);
        check("sh_wdata", r_wd, 32'hABCDABCD);
        check("sh_addr", r_addr, 32'h200);
        check("sh_rdata", r_rd, 32'h0);
        check("sh_cyc", 32'(r_cyc), 32'd4);

        // sb 0x101 and sw with a two-cycle response
        run_access(1'b1, 3'b000, 2'b00, 32'h101, 32'h000000EF, 1, 1, 32'h0);
        check("sb_be", 32'(r_be), 32'h2);
        check("sb_wdata", r_wd, 32'hEFEFEFEF);
        run_access(1'b1, 3'b000, 2'b10, 32'h300, 32'hCAFEF00D, 1, 2, 32'h0);
        check("sw_be", 32'(r_be), 32'hF);
        check("sw_wdata", r_wd, 32'hCAFEF00D);
        check("sw_cyc", 32'(r_cyc), 32'd5);

        // Reserved load type behaves as lw
        run_access(1'b0, 3'b111, 2'b00, 32'h104, 32'h0, 1, 1, 32'h13579BDF);
        check("ldrsv_be", 32'(r_be), 32'hF);
        check("ldrsv_rdata", r_rd, 32'h13579BDF);

        // Misaligned lw: no bus request, done on cycle 2
        run_access(1'b0, 3'b010, 2'b00, 32'h101, 32'h0, 1, 1, 32'h0);
        check("mis_cyc", 32'(r_cyc), 32'd2);
        check("mis_req_cnt", 32'(r_req_cnt), 32'd0);
        check("mis_flag", 32'(r_mis), 32'd1);
        check("mis_berr", 32'(r_berr), 32'd0);
        check("mis_rdata", r_rd, 32'h0);
        check("mis_stall_done", 32'(r_stall_done), 32'd0);

        // Reserved store type behaves as sw: misaligned at addr 2
        run_access(1'b1, 3'b000, 2'b11, 32'h2, 32'h0, 1, 1, 32'h0);
        check("strsv_mis", 32'(r_mis), 32'd1);
        check("strsv_req_cnt", 32'(r_req_cnt), 32'd0);

        // Load something nonzero, then timeout after a 3-cycle gnt wait
        run_access(1'b0, 3'b010, 2'b00, 32'h108, 32'h0, 1, 1, 32'hA5A5A5A5);
        check("pre_to_rdata", r_rd, 32'hA5A5A5A5);
        run_access(1'b0, 3'b010, 2'b00, 32'h10C, 32'h0, 3, 0, 32'h0);
        check("to_req_cnt", 32'(r_req_cnt), 32'd3);
        check("to_cyc", 32'(r_cyc), 32'd21);
        check("to_berr", 32'(r_berr), 32'd1);
        check("to_mis", 32'(r_mis), 32'd0);
        check("to_rdata", r_rd, 32'h0);

        // Reset while in REQ drops mem_req asynchronously
        @(negedge clk);
        req_load = 1'b1; load_type = 3'b010; addr = 32'h400;
        @(negedge clk); #1;
        check("rstreq_req_before", 32'(mem_req), 32'd1);
        reset_n = 1'b0; req_load = 1'b0;
        #1;
        check("rstreq_req_after", 32'(mem_req), 32'd0);
        check("rstreq_stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Load nonzero, then reset in RESP; a late rvalid must be ignored
        run_access(1'b0, 3'b010, 2'b00, 32'h110, 32'h0, 1, 1, 32'h0F0F0F0F);
        check("pre_rst_rdata", r_rd, 32'h0F0F0F0F);
        @(negedge clk);
        req_load = 1'b1; load_type = 3'b010; addr = 32'h500;
        @(negedge clk); #1;
        mem_gnt = 1'b1;
        @(negedge clk); #1;
        mem_gnt = 1'b0;
        check("rstresp_stall_before", 32'(stall), 32'd1);
        reset_n = 1'b0; req_load = 1'b0;
        #1;
        check("rstresp_stall", 32'(stall), 32'd0);
        check("rstresp_req", 32'(mem_req), 32'd0);
        check("rstresp_done", 32'(done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); #1;
        mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
        @(negedge clk); #1;
        mem_rvalid = 1'b0;
        check("late_rv_done", 32'(done), 32'd0);
        check("late_rv_stall", 32'(stall), 32'd0);
        check("late_rv_rdata", rdata_ext, 32'h0);
        @(negedge clk); #1;
        check("late_rv_done2", 32'(done), 32'd0);
        check("late_rv_req", 32'(mem_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
